// File: rtl/result_tx.sv
// Buffers result bytes and sends them as a frame (header=count, payload, checksum); one strobe per byte, one-cycle gap after each.
// Latency: header strobe in the cycle after send; producer is held off (res_ready=0) while full or framing; tx waits on tx_ready.
module result_tx #(
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] res_data,
   input  logic          res_valid,
   output logic          res_ready,
   input  logic          send,
   output logic [DW-1:0] tx_data,
   output logic          tx_enable,
   input  logic          tx_ready,
   output logic          busy,
   output logic          done
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, HDR, PAY, CHK, GAP, FIN} state_t;

   state_t        state, state_nxt, last_tx;
   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, remaining;
   logic [DW-1:0] checksum, tx_hold, cur_byte;
   logic          wr_en, strobe;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign res_ready = (state == IDLE) && (count < CW'(DEPTH)) && !send;
   assign wr_en     = res_valid && res_ready;
   assign tx_enable = strobe;
   assign tx_data   = strobe ? cur_byte : tx_hold;
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);

   always_comb begin
      state_nxt = state;
      strobe    = 1'b0;
      cur_byte  = tx_hold;
      case (state)
         IDLE: if (send && count != '0) state_nxt = HDR;
         HDR, PAY, CHK: begin
            if (state == HDR)      cur_byte = DW'(count);
            else if (state == PAY) cur_byte = mem[rd_ptr];
            else                   cur_byte = checksum;
            if (tx_ready) begin
               strobe    = 1'b1;
               state_nxt = GAP;
            end
         end
         // last_tx remembers which byte was just launched so the gap knows where to go
         GAP: begin
            case (last_tx)
               HDR:     state_nxt = PAY;
               PAY:     state_nxt = (remaining != '0) ? PAY : CHK;
               default: state_nxt = FIN;
            endcase
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         last_tx   <= IDLE;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         remaining <= '0;
         checksum  <= '0;
         tx_hold   <= '0;
      end else begin
         state <= state_nxt;
         if (wr_en) begin
            wr_ptr <= ptr_inc(wr_ptr);
            count  <= count + CW'(1);
         end
         if (state == IDLE && state_nxt == HDR) begin
            remaining <= count;
            checksum  <= '0;
         end
         if (strobe) begin
            tx_hold <= cur_byte;
            last_tx <= state;
            if (state != CHK) checksum <= checksum + cur_byte;
            if (state == PAY) begin
               rd_ptr    <= ptr_inc(rd_ptr);
               remaining <= remaining - CW'(1);
            end
         end
         if (state == FIN) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= res_data;
   end
endmodule

// File: tb/tb_result_tx.sv
// Self-checking bench for result_tx: table-driven frames, corner sequences and randomized frames against a frame model.
module tb_result_tx;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] res_data = '0;
   logic       res_valid = 1'b0;
   logic       res_ready;
   logic       send = 1'b0;
   logic [7:0] tx_data;
   logic       tx_enable;
   logic       tx_ready = 1'b1;
   logic       busy;
   logic       done;

   result_tx #(.DEPTH(16), .DW(8)) dut (
      .clk(clk), .reset(reset), .res_data(res_data), .res_valid(res_valid),
      .res_ready(res_ready), .send(send), .tx_data(tx_data), .tx_enable(tx_enable),
      .tx_ready(tx_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [7:0] got [$];
   int done_cnt = 0;
   int viol_consec = 0, viol_rdy = 0, viol_done = 0;
   logic prev_en = 1'b0, prev_done = 1'b0;
   logic rdy_low = 1'b0, rdy_rand = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Strobe monitor and protocol watch
   always @(negedge clk) begin
      if (reset) begin
         prev_en = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (tx_enable) begin
            got.push_back(tx_data);
            if (prev_en) viol_consec++;
            if (!tx_ready) viol_rdy++;
         end
         if (done) begin
            done_cnt++;
            if (prev_done) viol_done++;
         end
         prev_en = tx_enable;
         prev_done = done;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_ready = rdy_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   task automatic write_byte(input logic [7:0] b);
      int k;
      res_valid = 1'b1;
      res_data = b;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (res_ready) break;
      end
      if (k == 200) chk("write_timeout", 0, 1);
      @(posedge clk);
      #1;
      res_valid = 1'b0;
   endtask

   task automatic pulse_send();
      send = 1'b1;
      @(posedge clk);
      #1;
      send = 1'b0;
   endtask

   task automatic wait_done(input string name, input int d0);
      int k;
      for (k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
      chk({name, "_done_seen"}, int'(done_cnt != d0), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_strobes(input int n);
      int k;
      for (k = 0; k < 500 && got.size() < n; k++) @(negedge clk);
      chk("wait_strobes", int'(got.size() >= n), 1);
   endtask

   task automatic check_frame(input string name, input logic [7:0] exp [$]);
      chk({name, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s_b%0d", name, i), int'(got[i]), int'(exp[i]));
   endtask

   // Frame model: header=n, payload, sum of all mod 256
   function automatic void model(input logic [7:0] pay [$], output logic [7:0] exp [$]);
      int s;
      exp = {};
      exp.push_back(8'(pay.size()));
      s = pay.size();
      foreach (pay[i]) begin
         exp.push_back(pay[i]);
         s += int'(pay[i]);
      end
      exp.push_back(8'(s & 255));
   endfunction

   typedef struct packed {
      logic [4:0]       n;
      logic [15:0][7:0] pay;
      logic [7:0]       hdr;
      logic [7:0]       chk;
   } vec_t;

   initial begin
      vec_t vt [3];
      logic [7:0] pay [$];
      logic [7:0] exp [$];
      int d0;

      vt[0] = '0; vt[0].n = 3; vt[0].hdr = 8'h03; vt[0].chk = 8'h63;
      vt[0].pay[0] = 8'h10; vt[0].pay[1] = 8'h20; vt[0].pay[2] = 8'h30;
      vt[1] = '0; vt[1].n = 2; vt[1].hdr = 8'h02; vt[1].chk = 8'h00;
      vt[1].pay[0] = 8'hFF; vt[1].pay[1] = 8'hFF;
      vt[2] = '0; vt[2].n = 16; vt[2].hdr = 8'h10; vt[2].chk = 8'h08;
      for (int i = 0; i < 16; i++) vt[2].pay[i] = 8'(i * 17);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_tx_enable", tx_enable, 0);
      chk("rst_done", done, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_res_ready", res_ready, 1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < vt[v].n; i++) write_byte(vt[v].pay[i]);
         if (vt[v].n == 16) begin
            res_valid = 1'b1;
            res_data = 8'hEE;
            @(negedge clk);
            chk("full_res_ready", res_ready, 0);
            @(posedge clk);
            #1;
            res_valid = 1'b0;
         end
         got.delete();
         d0 = done_cnt;
         pulse_send();
         wait_done($sformatf("vec%0d", v), d0);
         exp = {};
         exp.push_back(vt[v].hdr);
         for (int i = 0; i < vt[v].n; i++) exp.push_back(vt[v].pay[i]);
         exp.push_back(vt[v].chk);
         check_frame($sformatf("vec%0d", v), exp);
         chk($sformatf("vec%0d_idle", v), busy, 0);
         chk($sformatf("vec%0d_count0", v), res_ready, 1);
         chk($sformatf("vec%0d_hold", v), tx_data, vt[v].chk);
      end

      // send with empty buffer
      got.delete();
      pulse_send();
      repeat (10) @(negedge clk);
      chk("empty_strobes", got.size(), 0);
      chk("empty_busy", busy, 0);
      @(posedge clk);
      #1;

      // send and writes while busy are ignored
      pay = {8'h01, 8'h02, 8'h03};
      foreach (pay[i]) write_byte(pay[i]);
      got.delete();
      d0 = done_cnt;
      pulse_send();
      wait_strobes(2);
      @(posedge clk);
      #1;
      send = 1'b1;
      res_valid = 1'b1;
      res_data = 8'h77;
      @(negedge clk);
      chk("busy_res_ready", res_ready, 0);
      @(posedge clk);
      #1;
      send = 1'b0;
      res_valid = 1'b0;
      wait_done("busy_send", d0);
      model(pay, exp);
      check_frame("busy_send", exp);
      repeat (5) @(negedge clk);
      chk("busy_send_no_refire", busy, 0);
      @(posedge clk);
      #1;

      // tx_ready low for 20 cycles during payload
      pay = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
      foreach (pay[i]) write_byte(pay[i]);
      got.delete();
      d0 = done_cnt;
      pulse_send();
      wait_strobes(2);
      rdy_low = 1'b1;
      repeat (21) @(negedge clk);
      chk("stall_no_strobe", got.size(), 2);
      chk("stall_busy", busy, 1);
      rdy_low = 1'b0;
      wait_done("stall", d0);
      model(pay, exp);
      check_frame("stall", exp);

      // reset mid-frame
      pay = {8'h55, 8'h66, 8'h77};
      foreach (pay[i]) write_byte(pay[i]);
      got.delete();
      pulse_send();
      wait_strobes(2);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_mid_tx_enable", tx_enable, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_tx_data", tx_data, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_mid_strobes", got.size(), 2);
      pulse_send();
      repeat (10) @(negedge clk);
      chk("rst_mid_resend_strobes", got.size(), 2);
      chk("rst_mid_resend_busy", busy, 0);
      @(posedge clk);
      #1;

      // randomized frames with random tx_ready
      rdy_rand = 1'b1;
      for (int f = 0; f < 10; f++) begin
         int n;
         n = $urandom_range(1, 16);
         pay = {};
         for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
         foreach (pay[i]) write_byte(pay[i]);
         got.delete();
         d0 = done_cnt;
         pulse_send();
         wait_done($sformatf("rnd%0d", f), d0);
         model(pay, exp);
         check_frame($sformatf("rnd%0d", f), exp);
      end
      rdy_rand = 1'b0;

      chk("proto_consecutive", viol_consec, 0);
      chk("proto_enable_not_ready", viol_rdy, 0);
      chk("proto_done_width", viol_done, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d expected 0", 1);
      $fatal(1);
   end
endmodule
